// File: rtl/stream_downsampler_2x2_if.sv
// Pixel stream handshake bundle for the 2x2 downsampler: input stream plus output stream.
interface stream_downsampler_2x2_if #(
  parameter int DATA_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/stream_downsampler_2x2.sv
// Streaming 2:1 x 2:1 downsampler (decimate / max / rounded average) using a half-width line buffer.
module stream_downsampler_2x2 #(
  parameter int DATA_W   = 8,
  parameter int MAX_COLS = 64,
  parameter int DIM_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIM_W-1:0]      cfg_cols,
  input  logic [DIM_W-1:0]      cfg_rows,
  input  logic [1:0]            cfg_mode,
  stream_downsampler_2x2_if.slave strm,
  output logic                  frame_done
);

  typedef enum logic [1:0] {IDLE, EVEN, ODD} state_e;

  localparam int LB_DEPTH = MAX_COLS / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam logic [DIM_W-1:0] MAX_COLS_D = DIM_W'(MAX_COLS);
  localparam logic [DIM_W-1:0] ONE_D      = DIM_W'(1);
  localparam logic [DIM_W-1:0] TWO_D      = DIM_W'(2);

  state_e            state_q, state_d;
  logic [DIM_W-1:0]  col_q, col_d, row_q, row_d;
  logic [DIM_W-1:0]  cols_q, cols_d, rows_q, rows_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] h_reg_q, h_reg_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              frame_done_q, frame_done_d;

  logic [DATA_W:0]   linebuf_q [LB_DEPTH];
  logic              lb_we;
  logic [LB_AW-1:0]  lb_idx;
  logic [DATA_W:0]   lb_wdata;

  logic              in_rdy, accept, first;
  logic [DIM_W-1:0]  cols_e, rows_e, col_e, row_e;
  logic [1:0]        mode_e;
  logic              degen, last_col, last_row, keep, blk_last;
  logic [DATA_W-1:0] px;
  logic [DATA_W:0]   h, lb, lb_max;
  logic [DATA_W+1:0] avg_sum;
  logic [DATA_W-1:0] result;

  always_comb begin
    in_rdy = !out_valid_q || strm.out_ready;
    accept = strm.in_valid && in_rdy;
    first  = (state_q == IDLE);

    // The first beat of a frame is processed with the live cfg and position (0,0).
    cols_e = first ? cfg_cols : cols_q;
    rows_e = first ? cfg_rows : rows_q;
    mode_e = first ? cfg_mode : mode_q;
    col_e  = first ? '0 : col_q;
    row_e  = first ? '0 : row_q;

    degen    = (cols_e < TWO_D) || (rows_e < TWO_D) || (cols_e > MAX_COLS_D);
    last_col = (col_e == cols_e - ONE_D) || (cols_e == '0);
    last_row = (row_e == rows_e - ONE_D) || (rows_e == '0);
    keep     = !degen && !(cols_e[0] && last_col) && !(rows_e[0] && last_row);
    blk_last = ((col_e >> 1) == ((cols_e >> 1) - ONE_D)) &&
               ((row_e >> 1) == ((rows_e >> 1) - ONE_D));

    px     = strm.in_data;
    lb_idx = LB_AW'(col_e >> 1);
    lb     = linebuf_q[lb_idx];

    case (mode_e)
      2'b01:   h = {1'b0, (h_reg_q > px) ? h_reg_q : px};
      2'b10:   h = {1'b0, h_reg_q} + {1'b0, px};
      default: h = {1'b0, h_reg_q};
    endcase

    avg_sum = {1'b0, lb} + {1'b0, h} + (DATA_W+2)'(2);
    lb_max  = (lb > h) ? lb : h;
    case (mode_e)
      2'b01:   result = DATA_W'(lb_max);
      2'b10:   result = DATA_W'(avg_sum >> 2);
      default: result = DATA_W'(lb);
    endcase
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    cols_d       = cols_q;
    rows_d       = rows_q;
    mode_d       = mode_q;
    h_reg_d      = h_reg_q;
    lb_we        = 1'b0;
    lb_wdata     = h;
    out_valid_d  = out_valid_q && !strm.out_ready;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;

    if (accept) begin
      if (first) begin
        cols_d = cfg_cols;
        rows_d = cfg_rows;
        mode_d = cfg_mode;
      end

      if (keep) begin
        if (!col_e[0]) begin
          h_reg_d = px;
        end else if (!row_e[0]) begin
          lb_we = 1'b1;
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = result;
          out_last_d  = blk_last;
        end
      end

      if (last_col) begin
        col_d = '0;
        if (last_row) begin
          row_d        = '0;
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end else begin
          row_d   = row_e + ONE_D;
          state_d = row_d[0] ? ODD : EVEN;
        end
      end else begin
        col_d   = col_e + ONE_D;
        row_d   = row_e;
        state_d = row_e[0] ? ODD : EVEN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      cols_q       <= '0;
      rows_q       <= '0;
      mode_q       <= '0;
      h_reg_q      <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      cols_q       <= cols_d;
      rows_q       <= rows_d;
      mode_q       <= mode_d;
      h_reg_q      <= h_reg_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lb_we) linebuf_q[lb_idx] <= lb_wdata;
  end

  assign strm.in_ready  = in_rdy;
  assign strm.out_valid = out_valid_q;
  assign strm.out_data  = out_data_q;
  assign strm.out_last  = out_last_q;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_stream_downsampler_2x2.sv
// Directed self-checking bench for stream_downsampler_2x2.
module tb_stream_downsampler_2x2;

  typedef logic [7:0] pxq_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] cfg_cols = '0;
  logic [7:0] cfg_rows = '0;
  logic [1:0] cfg_mode = '0;
  logic       frame_done;

  stream_downsampler_2x2_if #(.DATA_W(8)) bus ();

  stream_downsampler_2x2 #(.DATA_W(8), .MAX_COLS(64), .DIM_W(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_cols   (cfg_cols),
    .cfg_rows   (cfg_rows),
    .cfg_mode   (cfg_mode),
    .strm       (bus),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [8:0]  out_q[$];
  int unsigned beat_q[$];
  int unsigned fd_beat_q[$];
  int unsigned beats = 0;
  int unsigned rd = 0;

  // Handshakes complete at the posedge following this negedge.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      out_q.push_back({bus.out_last, bus.out_data});
      beat_q.push_back(beats);
    end
    if (frame_done) fd_beat_q.push_back(beats);
    if (bus.in_valid && bus.in_ready) beats++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_px(input logic [7:0] px, output int unsigned stalls);
    logic acc;
    int unsigned n;
    acc = 1'b0;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = px;
    while (!acc && n < 64) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    stalls = n - 1;
    bus.in_valid = 1'b0;
    if (!acc) chk("accept_timeout", {31'b0, acc}, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] cols, input logic [7:0] rows, input logic [1:0] mode,
                            input pxq_t px, input bit scramble, output int unsigned stalls);
    int unsigned s;
    cfg_cols = cols;
    cfg_rows = rows;
    cfg_mode = mode;
    stalls = 0;
    foreach (px[i]) begin
      send_px(px[i], s);
      stalls += s;
      if (scramble && i == 0) begin
        cfg_cols = 8'd3;
        cfg_rows = 8'd3;
        cfg_mode = 2'b10;
      end
    end
  endtask

  task automatic flush(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_out(input string tag, input logic [7:0] d, input logic l,
                         input bit cb, input int unsigned eb);
    logic [8:0] o;
    int unsigned b;
    if (rd < out_q.size()) begin
      o = out_q[rd];
      b = beat_q[rd];
    end else begin
      o = 'x;
      b = 32'hFFFF_FFFF;
    end
    rd++;
    chk(tag, {23'b0, o}, {23'b0, l, d});
    if (cb) chk({tag, "_beat"}, b, eb);
  endtask

  function automatic pxq_t ramp(input int unsigned n);
    pxq_t q;
    for (int unsigned i = 0; i < n; i++) q.push_back(8'(i));
    return q;
  endfunction

  function automatic pxq_t fill(input int unsigned n, input logic [7:0] v);
    pxq_t q;
    for (int unsigned i = 0; i < n; i++) q.push_back(v);
    return q;
  endfunction

  initial begin
    int unsigned st, st2, base, fd0, snap;
    pxq_t q3;
    logic [7:0] exp3 [4];
    logic [7:0] avg_in [4][4];
    logic [7:0] avg_exp [4];

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    flush(2);

    chk("rst_out_valid",  {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_data",   {24'b0, bus.out_data},  32'd0);
    chk("rst_out_last",   {31'b0, bus.out_last},  32'd0);
    chk("rst_frame_done", {31'b0, frame_done},    32'd0);
    chk("rst_in_ready",   {31'b0, bus.in_ready},  32'd1);
    rst_n = 1'b1;
    flush(1);

    // 3x3 frame, every mode; 11 behaves as decimate
    q3 = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
    exp3 = '{8'd0, 8'd3, 8'd1, 8'd0};
    for (int m = 0; m < 4; m++) begin
      fd0 = fd_beat_q.size();
      snap = out_q.size();
      send_frame(8'd3, 8'd3, 2'(m), q3, 1'b0, st);
      flush(4);
      chk($sformatf("m3x3_%0d_nout", m), out_q.size() - snap, 32'd1);
      pop_out($sformatf("m3x3_%0d_out", m), exp3[m], 1'b1, 1'b0, 0);
      chk($sformatf("m3x3_%0d_fdone", m), fd_beat_q.size() - fd0, 32'd1);
    end

    // 4x4 ramp, max, full throughput and latency
    base = beats;
    fd0 = fd_beat_q.size();
    send_frame(8'd4, 8'd4, 2'b01, ramp(16), 1'b0, st);
    flush(4);
    chk("ramp_stalls", st, 32'd0);
    chk("ramp_nout", out_q.size() - rd, 32'd4);
    pop_out("ramp_o0", 8'd5,  1'b0, 1'b1, base + 6);
    pop_out("ramp_o1", 8'd7,  1'b0, 1'b1, base + 8);
    pop_out("ramp_o2", 8'd13, 1'b0, 1'b1, base + 14);
    pop_out("ramp_o3", 8'd15, 1'b1, 1'b1, base + 16);
    chk("ramp_fd_count", fd_beat_q.size() - fd0, 32'd1);
    chk("ramp_fd_beat", (fd0 < fd_beat_q.size()) ? fd_beat_q[fd0] : 32'hFFFF_FFFF, base + 16);

    // rounded average blocks
    avg_in  = '{'{8'd1, 8'd2, 8'd2, 8'd2}, '{8'd255, 8'd255, 8'd255, 8'd255},
                '{8'd0, 8'd0, 8'd0, 8'd1}, '{8'd0, 8'd0, 8'd1, 8'd1}};
    avg_exp = '{8'd2, 8'd255, 8'd0, 8'd1};
    for (int k = 0; k < 4; k++) begin
      send_frame(8'd2, 8'd2, 2'b10,
                 '{avg_in[k][0], avg_in[k][1], avg_in[k][2], avg_in[k][3]}, 1'b0, st);
      flush(3);
      pop_out($sformatf("avg_%0d", k), avg_exp[k], 1'b1, 1'b0, 0);
    end

    // degenerate 1x3 frame: consumed silently, frame_done still fires
    fd0 = fd_beat_q.size();
    snap = out_q.size();
    send_frame(8'd1, 8'd3, 2'b00, '{8'd7, 8'd7, 8'd7}, 1'b0, st);
    flush(3);
    chk("degen_nout", out_q.size() - snap, 32'd0);
    chk("degen_fdone", fd_beat_q.size() - fd0, 32'd1);

    // backpressure: hold out_ready low for 5 cycles once the first output is up
    bus.out_ready = 1'b0;
    fork
      send_frame(8'd4, 8'd4, 2'b01, ramp(16), 1'b0, st);
      begin
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 40) begin
          @(negedge clk);
          n++;
        end
        chk("bp_wait", {31'b0, bus.out_valid}, 32'd1);
        for (int c = 0; c < 5; c++) begin
          if (c > 0) @(negedge clk);
          chk($sformatf("bp_valid_%0d", c), {31'b0, bus.out_valid}, 32'd1);
          chk($sformatf("bp_data_%0d", c),  {24'b0, bus.out_data},  32'd5);
          chk($sformatf("bp_ready_%0d", c), {31'b0, bus.in_ready},  32'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    flush(4);
    chk("bp_stalls", {31'b0, st >= 5}, 32'd1);
    chk("bp_nout", out_q.size() - rd, 32'd4);
    pop_out("bp_o0", 8'd5,  1'b0, 1'b0, 0);
    pop_out("bp_o1", 8'd7,  1'b0, 1'b0, 0);
    pop_out("bp_o2", 8'd13, 1'b0, 1'b0, 0);
    pop_out("bp_o3", 8'd15, 1'b1, 1'b0, 0);

    // back-to-back frames with mid-frame cfg scrambling
    base = beats;
    fd0 = fd_beat_q.size();
    send_frame(8'd4, 8'd4, 2'b01, ramp(16), 1'b1, st);
    send_frame(8'd2, 8'd6, 2'b00, fill(12, 8'd9), 1'b1, st2);
    flush(4);
    chk("b2b_stalls", st + st2, 32'd0);
    chk("b2b_nout", out_q.size() - rd, 32'd7);
    pop_out("b2b_a0", 8'd5,  1'b0, 1'b0, 0);
    pop_out("b2b_a1", 8'd7,  1'b0, 1'b0, 0);
    pop_out("b2b_a2", 8'd13, 1'b0, 1'b0, 0);
    pop_out("b2b_a3", 8'd15, 1'b1, 1'b0, 0);
    pop_out("b2b_b0", 8'd9,  1'b0, 1'b0, 0);
    pop_out("b2b_b1", 8'd9,  1'b0, 1'b0, 0);
    pop_out("b2b_b2", 8'd9,  1'b1, 1'b1, base + 28);
    chk("b2b_fd_count", fd_beat_q.size() - fd0, 32'd2);
    chk("b2b_fd1_beat", (fd0 + 1 < fd_beat_q.size()) ? fd_beat_q[fd0+1] : 32'hFFFF_FFFF, base + 28);

    // reset mid-frame after 6 beats
    cfg_cols = 8'd4;
    cfg_rows = 8'd4;
    cfg_mode = 2'b01;
    for (int i = 0; i < 6; i++) send_px(8'(i), st);
    chk("mrst_pre_valid", {31'b0, bus.out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("mrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    flush(1);
    rst_n = 1'b1;
    flush(1);
    rd = out_q.size();
    fd0 = fd_beat_q.size();
    send_frame(8'd4, 8'd4, 2'b01, ramp(16), 1'b0, st);
    flush(4);
    chk("mrst_nout", out_q.size() - rd, 32'd4);
    pop_out("mrst_o0", 8'd5,  1'b0, 1'b0, 0);
    pop_out("mrst_o1", 8'd7,  1'b0, 1'b0, 0);
    pop_out("mrst_o2", 8'd13, 1'b0, 1'b0, 0);
    pop_out("mrst_o3", 8'd15, 1'b1, 1'b0, 0);
    chk("mrst_fd_count", fd_beat_q.size() - fd0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
